// File: rtl/enc8b10b_lanes.sv
// Multi-lane 8b/10b encoder with running disparity chained across lanes and beats,
// one registered valid/ready output stage. Optional K-error counter: ENC_KERR_CNT_EN.

module enc8b10b_lane (
    input  logic [7:0] i_byte,
    input  logic       i_k,
    input  logic       i_rd,
    output logic [9:0] o_code,
    output logic       o_rd,
    output logic       o_kerr
);
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28, w_k7, w_unbal6, w_flip6, w_rd4, w_a7, w_unbal4, w_flip4;
    logic [5:0] w_base6, w_six;
    logic [3:0] w_base4, w_four;

    assign w_x    = i_byte[4:0];
    assign w_y    = i_byte[7:5];
    assign w_k28  = i_k && (w_x == 5'd28);
    assign w_k7   = i_k && (w_y == 3'd7) &&
                    (w_x == 5'd23 || w_x == 5'd27 || w_x == 5'd29 || w_x == 5'd30);
    assign o_kerr = i_k && !w_k28 && !w_k7;

    // abcdei as sent from RD-
    always_comb begin
        w_base6 = 6'b000000;
        case (w_x)
            5'd0:  w_base6 = 6'b100111;  5'd1:  w_base6 = 6'b011101;
            5'd2:  w_base6 = 6'b101101;  5'd3:  w_base6 = 6'b110001;
            5'd4:  w_base6 = 6'b110101;  5'd5:  w_base6 = 6'b101001;
            5'd6:  w_base6 = 6'b011001;  5'd7:  w_base6 = 6'b111000;
            5'd8:  w_base6 = 6'b111001;  5'd9:  w_base6 = 6'b100101;
            5'd10: w_base6 = 6'b010101;  5'd11: w_base6 = 6'b110100;
            5'd12: w_base6 = 6'b001101;  5'd13: w_base6 = 6'b101100;
            5'd14: w_base6 = 6'b011100;  5'd15: w_base6 = 6'b010111;
            5'd16: w_base6 = 6'b011011;  5'd17: w_base6 = 6'b100011;
            5'd18: w_base6 = 6'b010011;  5'd19: w_base6 = 6'b110010;
            5'd20: w_base6 = 6'b001011;  5'd21: w_base6 = 6'b101010;
            5'd22: w_base6 = 6'b011010;  5'd23: w_base6 = 6'b111010;
            5'd24: w_base6 = 6'b110011;  5'd25: w_base6 = 6'b100110;
            5'd26: w_base6 = 6'b010110;  5'd27: w_base6 = 6'b110110;
            5'd28: w_base6 = 6'b001110;  5'd29: w_base6 = 6'b101110;
            5'd30: w_base6 = 6'b011110;  default: w_base6 = 6'b101011;
        endcase
        if (w_k28)
            w_base6 = 6'b001111;
    end

    assign w_unbal6 = ($countones(w_base6) != 3);
    assign w_flip6  = w_unbal6 || (w_base6 == 6'b111000);
    assign w_six    = (i_rd && w_flip6) ? ~w_base6 : w_base6;
    assign w_rd4    = i_rd ^ w_unbal6;

    // A7 avoids a run of five equal bits across the e/i..f/g boundary
    assign w_a7 = w_k28 || w_k7 || (!w_rd4 && w_six[1] && w_six[0]) ||
                  (w_rd4 && !w_six[1] && !w_six[0]);

    always_comb begin
        w_base4 = 4'b0000;
        case (w_y)
            3'd0:    w_base4 = 4'b1011;
            3'd1:    w_base4 = 4'b1001;
            3'd2:    w_base4 = 4'b0101;
            3'd3:    w_base4 = 4'b1100;
            3'd4:    w_base4 = 4'b1101;
            3'd5:    w_base4 = 4'b1010;
            3'd6:    w_base4 = 4'b0110;
            default: w_base4 = w_a7 ? 4'b0111 : 4'b1110;
        endcase
    end

    assign w_unbal4 = (w_y == 3'd0) || (w_y == 3'd4) || (w_y == 3'd7);
    // K28 balanced sub-blocks are inverted relative to data so the comma stays intact
    assign w_flip4  = (w_k28 && !w_unbal4 && w_y != 3'd3) ? !w_rd4
                                                          : (w_rd4 && (w_unbal4 || w_y == 3'd3));
    assign w_four   = w_flip4 ? ~w_base4 : w_base4;
    assign o_code   = {w_six, w_four};
    assign o_rd     = w_rd4 ^ w_unbal4;
endmodule

module enc8b10b_lanes #(
    parameter int   LANES   = 1,
    parameter logic INIT_RD = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [LANES-1:0]   in_k,
    input  logic               rd_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [10*LANES-1:0] out_code,
    output logic [LANES-1:0]   out_kerr,
    output logic               out_rd
`ifdef ENC_KERR_CNT_EN
    ,
    output logic [15:0]        kerr_cnt,
    input  logic               kerr_cnt_clr
`endif
);
    logic                 r_valid, r_rd, r_rd_out;
    logic [10*LANES-1:0]  r_code;
    logic [LANES-1:0]     r_kerr;
    logic                 w_acc;
    logic [LANES:0]       w_rd_chain;
    logic [LANES-1:0][9:0] w_code;
    logic [LANES-1:0]     w_kerr;

    assign in_ready      = !r_valid || out_ready;
    assign w_acc         = in_valid && in_ready;
    assign w_rd_chain[0] = rd_clr ? INIT_RD : r_rd;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        enc8b10b_lane u_lane (
            .i_byte (in_data[8*g +: 8]),
            .i_k    (in_k[g]),
            .i_rd   (w_rd_chain[g]),
            .o_code (w_code[g]),
            .o_rd   (w_rd_chain[g+1]),
            .o_kerr (w_kerr[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_code   <= '0;
            r_kerr   <= '0;
            r_rd     <= INIT_RD;
            r_rd_out <= INIT_RD;
        end else if (w_acc) begin
            r_valid  <= 1'b1;
            r_code   <= w_code;
            r_kerr   <= w_kerr;
            r_rd     <= w_rd_chain[LANES];
            r_rd_out <= w_rd_chain[LANES];
        end else begin
            if (rd_clr)
                r_rd <= INIT_RD;
            if (out_ready)
                r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_kerr  = r_kerr;
    assign out_rd    = r_rd_out;

`ifdef ENC_KERR_CNT_EN
    logic [15:0] r_kerr_cnt;
    logic [16:0] w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_kerr_cnt} + 17'($countones(w_kerr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_kerr_cnt <= 16'd0;
        else if (kerr_cnt_clr)
            r_kerr_cnt <= 16'd0;
        else if (w_acc)
            r_kerr_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    assign kerr_cnt = r_kerr_cnt;
`endif
endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Directed bench for enc8b10b_lanes: one LANES=1 and one LANES=4 instance,
// expected codes hand-derived from the 5b/6b and 3b/4b tables.

module tb_enc8b10b_lanes;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v1 = 0, k1 = 0, clr1 = 0, or1 = 1;
    logic        rdy1, ov1, rdo1;
    logic [7:0]  d1 = '0;
    logic [9:0]  code1;
    logic [0:0]  kerr1;

    logic        v4 = 0, clr4 = 0, or4 = 1;
    logic        rdy4, ov4, rdo4;
    logic [31:0] d4 = '0;
    logic [3:0]  k4 = '0;
    logic [3:0]  kerr4;
    logic [39:0] code4;

    int n_vec = 0;
    int n_err = 0;

`ifdef ENC_KERR_CNT_EN
    logic [15:0] kc1, kc4;
    logic        kcc = 1'b0;
`endif

    enc8b10b_lanes #(.LANES(1), .INIT_RD(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .in_k(k1), .rd_clr(clr1), .out_valid(ov1), .out_ready(or1), .out_code(code1),
        .out_kerr(kerr1), .out_rd(rdo1)
`ifdef ENC_KERR_CNT_EN
        , .kerr_cnt(kc1), .kerr_cnt_clr(kcc)
`endif
    );

    enc8b10b_lanes #(.LANES(4), .INIT_RD(1'b0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .in_k(k4), .rd_clr(clr4), .out_valid(ov4), .out_ready(or4), .out_code(code4),
        .out_kerr(kerr4), .out_rd(rdo4)
`ifdef ENC_KERR_CNT_EN
        , .kerr_cnt(kc4), .kerr_cnt_clr(kcc)
`endif
    );

    // byte, k, code, rd-after; consecutive single-lane beats starting from RD-
    localparam int NDATA = 11;
    localparam logic [7:0] TB_B [NDATA] = '{8'h00, 8'h00, 8'hB5, 8'hBC, 8'h00, 8'hB5,
                                            8'hEB, 8'hF1, 8'hE0, 8'hFC, 8'hF7};
    localparam logic       TB_K [NDATA] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [9:0] TB_C [NDATA] = '{10'h274, 10'h274, 10'h2AA, 10'h0FA, 10'h18B, 10'h2AA,
                                            10'h348, 10'h237, 10'h18E, 10'h307, 10'h057};
    localparam logic       TB_R [NDATA] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                            1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v1 = 0; k1 = 0; clr1 = 0; or1 = 1; d1 = '0;
        v4 = 0; k4 = '0; clr4 = 0; or4 = 1; d4 = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1 got %b exp 0", ov1); end
        n_vec++; if (code1 !== 10'h000) begin n_err++; $display("FAIL reset_code1 got %h exp 000", code1); end
        n_vec++; if (kerr1 !== 1'b0) begin n_err++; $display("FAIL reset_kerr1 got %b exp 0", kerr1); end
        n_vec++; if (rdo1 !== 1'b0) begin n_err++; $display("FAIL reset_rd1 got %b exp 0", rdo1); end
        n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_ready1 got %b exp 1", rdy1); end
        n_vec++; if (ov4 !== 1'b0 || code4 !== 40'h0) begin n_err++; $display("FAIL reset_out4 got %b/%h exp 0/0", ov4, code4); end
`ifdef ENC_KERR_CNT_EN
        n_vec++; if (kc1 !== 16'd0) begin n_err++; $display("FAIL reset_kcnt got %0d exp 0", kc1); end
`endif
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_k28();
        do_reset();
        v1 = 1; d1 = 8'hBC; k1 = 1;
        tick();
        n_vec++; if (code1 !== 10'h0FA || rdo1 !== 1'b1 || ov1 !== 1'b1)
            begin n_err++; $display("FAIL k28_5_rdm got %h/%b/%b exp 0fa/1/1", code1, rdo1, ov1); end
        n_vec++; if (kerr1 !== 1'b0) begin n_err++; $display("FAIL k28_5_kerr got %b exp 0", kerr1); end
        tick();
        n_vec++; if (code1 !== 10'h305 || rdo1 !== 1'b0)
            begin n_err++; $display("FAIL k28_5_rdp got %h/%b exp 305/0", code1, rdo1); end
        v1 = 0; k1 = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < NDATA; i++) begin
            v1 = 1; d1 = TB_B[i]; k1 = TB_K[i];
            tick();
            n_vec++;
            if (code1 !== TB_C[i] || rdo1 !== TB_R[i] || ov1 !== 1'b1)
                begin n_err++; $display("FAIL stream[%0d] got %h/%b/%b exp %h/%b/1", i, code1, rdo1, ov1, TB_C[i], TB_R[i]); end
        end
        v1 = 0; k1 = 0;
        tick();
        n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b exp 0", ov1); end
    endtask

    task automatic test_lanes4();
        logic [39:0] exp;
        do_reset();
        v4 = 1;
        d4 = {8'h00, 8'hBC, 8'h00, 8'hBC}; k4 = 4'b0101;
        tick();
        exp = {10'h274, 10'h305, 10'h18B, 10'h0FA};
        n_vec++; if (code4 !== exp || rdo4 !== 1'b0)
            begin n_err++; $display("FAIL lanes4_mix got %h/%b exp %h/0", code4, rdo4, exp); end
        d4 = {4{8'hBC}}; k4 = 4'b1111;
        tick();
        exp = {10'h305, 10'h0FA, 10'h305, 10'h0FA};
        n_vec++; if (code4 !== exp || rdo4 !== 1'b0)
            begin n_err++; $display("FAIL lanes4_k got %h/%b exp %h/0", code4, rdo4, exp); end
        d4 = {8'h00, 8'h00, 8'h00, 8'hBC}; k4 = 4'b0001;
        tick();
        exp = {10'h18B, 10'h18B, 10'h18B, 10'h0FA};
        n_vec++; if (code4 !== exp || rdo4 !== 1'b1)
            begin n_err++; $display("FAIL lanes4_rdp got %h/%b exp %h/1", code4, rdo4, exp); end
        d4 = {4{8'h00}}; k4 = 4'b0000;
        tick();
        exp = {4{10'h18B}};
        n_vec++; if (code4 !== exp || rdo4 !== 1'b1)
            begin n_err++; $display("FAIL lanes4_carry got %h/%b exp %h/1", code4, rdo4, exp); end
        d4 = {8'hFE, 8'hFB, 8'h55, 8'hBC}; k4 = 4'b1111;
        tick();
        n_vec++; if (kerr4 !== 4'b0010)
            begin n_err++; $display("FAIL lanes4_kerr got %b exp 0010", kerr4); end
        v4 = 0; k4 = '0;
    endtask

    task automatic test_stall();
        do_reset();
        v1 = 1; d1 = 8'hBC; k1 = 1;
        tick();
        or1 = 0; d1 = 8'h00; k1 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (rdy1 !== 1'b0 || ov1 !== 1'b1 || code1 !== 10'h0FA || rdo1 !== 1'b1)
                begin n_err++; $display("FAIL stall[%0d] got rdy=%b v=%b %h/%b exp 0 1 0fa/1", i, rdy1, ov1, code1, rdo1); end
        end
        or1 = 1;
        #1;
        n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b exp 1", rdy1); end
        tick();
        n_vec++; if (code1 !== 10'h18B || rdo1 !== 1'b1 || ov1 !== 1'b1)
            begin n_err++; $display("FAIL stall_next got %h/%b exp 18b/1", code1, rdo1); end
        v1 = 0;
        tick();
        n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL stall_drop got %b exp 0", ov1); end
    endtask

    task automatic test_kerr();
        do_reset();
        v1 = 1; d1 = 8'h00; k1 = 1;
        tick();
        n_vec++; if (kerr1 !== 1'b1 || code1 !== 10'h274 || rdo1 !== 1'b0)
            begin n_err++; $display("FAIL kerr_illegal got %b/%h/%b exp 1/274/0", kerr1, code1, rdo1); end
`ifdef ENC_KERR_CNT_EN
        n_vec++; if (kc1 !== 16'd1) begin n_err++; $display("FAIL kerr_cnt got %0d exp 1", kc1); end
`endif
        d1 = 8'hFE;
        tick();
        n_vec++; if (kerr1 !== 1'b0) begin n_err++; $display("FAIL kerr_k30_7 got %b exp 0", kerr1); end
        v1 = 0; k1 = 0;
    endtask

    task automatic test_rdclr();
        do_reset();
        v1 = 1; d1 = 8'hBC; k1 = 1;
        tick();
        d1 = 8'h00; k1 = 0; clr1 = 1;
        tick();
        n_vec++; if (code1 !== 10'h274 || rdo1 !== 1'b0)
            begin n_err++; $display("FAIL rdclr_accept got %h/%b exp 274/0", code1, rdo1); end
        clr1 = 0; d1 = 8'hBC; k1 = 1;
        tick();
        v1 = 0; k1 = 0; clr1 = 1;
        tick();
        n_vec++; if (ov1 !== 1'b0 || rdo1 !== 1'b1)
            begin n_err++; $display("FAIL rdclr_idle got v=%b rd=%b exp 0/1", ov1, rdo1); end
        clr1 = 0; v1 = 1; d1 = 8'h00;
        tick();
        n_vec++; if (code1 !== 10'h274 || rdo1 !== 1'b0)
            begin n_err++; $display("FAIL rdclr_later got %h/%b exp 274/0", code1, rdo1); end
        v1 = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        v1 = 1; d1 = 8'hBC; k1 = 1;
        tick();
        v1 = 0;
        rst_n = 1'b0;
        #1;
        n_vec++; if (ov1 !== 1'b0 || rdo1 !== 1'b0 || code1 !== 10'h000)
            begin n_err++; $display("FAIL midreset got %b/%b/%h exp 0/0/000", ov1, rdo1, code1); end
        tick();
        rst_n = 1'b1;
        v1 = 1;
        tick();
        n_vec++; if (code1 !== 10'h0FA || rdo1 !== 1'b1)
            begin n_err++; $display("FAIL midreset_resume got %h/%b exp 0fa/1", code1, rdo1); end
        v1 = 0; k1 = 0;
    endtask

    initial begin
        test_reset();
        test_k28();
        test_back_to_back();
        test_lanes4();
        test_stall();
        test_kerr();
        test_rdclr();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
